interrupt_controller: RTL



---
 rtl/pic_pkg.sv | 64 ++++++
 rtl/pic_priority.sv | 41 ++++
 rtl/interrupt_controller.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// ---------------------------------------------------------------------------
// pic_pkg
// Shared constants, types and helpers for the simplified 8259-style
// interrupt controller (interrupt_controller and pic_priority).
//
// Contents:
//   - number of request lines
//   - bus word / byte offsets of the register map
//   - command-byte bit positions for EOI decoding
//   - spurious vector level
//   - command decode and lowest-set-bit helpers
// ---------------------------------------------------------------------------
package pic_pkg;

  localparam int NUM_IRQ = 8;

  // Word offsets selected by data_m_addr[1]
  localparam logic WORD_CTRL   = 1'b0;  // byte0: command / IRR, byte1: IMR
  localparam logic WORD_STATUS = 1'b1;  // byte0: ISR, byte1: vector base

  // Byte lanes within a word (index into data_m_bytesel)
  localparam int BYTE_LO = 0;
  localparam int BYTE_HI = 1;

  // Command byte decoding
  localparam int EOI_BIT      = 5;
  localparam int SPECIFIC_BIT = 6;

  // Level reported in the vector when an acknowledge finds nothing eligible
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  typedef logic [NUM_IRQ-1:0] irq_vec_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_EOI_NONSPEC,
    CMD_EOI_SPECIFIC
  } cmd_e;

  // Classify a byte written to the command register.
  function automatic cmd_e decode_cmd(input logic [7:0] cmd);
    cmd_e result;
    result = CMD_NONE;
    if (cmd[EOI_BIT] && cmd[SPECIFIC_BIT]) begin
      result = CMD_EOI_SPECIFIC;
    end else if (cmd[EOI_BIT]) begin
      result = CMD_EOI_NONSPEC;
    end
    return result;
  endfunction

  // One-hot mask of the lowest-numbered set bit (all zero when v is zero).
  function automatic irq_vec_t lowest_set(input irq_vec_t v);
    irq_vec_t mask;
    mask = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (v[i] && (mask == '0)) begin
        mask[i] = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/pic_priority.sv
// ---------------------------------------------------------------------------
// pic_priority
// Combinational fixed-priority resolver. A line is eligible when it is
// requested, not masked, and no in-service bit at the same or a higher
// priority (lower index) is set. The lowest-numbered eligible line wins.
//
// Ports:
//   irr   in  [NUM_IRQ-1:0]  pending requests
//   imr   in  [NUM_IRQ-1:0]  mask, 1 = masked
//   isr   in  [NUM_IRQ-1:0]  in-service bits
//   any   out                at least one line is eligible
//   level out [2:0]          index of the winning line (0 when none)
// ---------------------------------------------------------------------------
module pic_priority
  import pic_pkg::*;
(
  input  logic [NUM_IRQ-1:0] irr,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic [NUM_IRQ-1:0] isr,
  output logic               any,
  output logic [2:0]         level
);

  logic blocked;

  // Walk from highest priority down. Once any in-service bit has been
  // passed, every lower-priority line is held off until that service ends.
  always_comb begin
    any     = 1'b0;
    level   = 3'd0;
    blocked = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      blocked = blocked | isr[i];
      if (!any && !blocked && irr[i] && !imr[i]) begin
        any   = 1'b1;
        level = 3'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
// Simplified 8259-style programmable interrupt controller: edge-triggered
// request capture, per-line mask, fixed priority (IRQ0 highest) with
// in-service nesting, non-specific / specific EOI, and a vector strobe on
// each CPU acknowledge. Software access uses the 16-bit data_m_* slave bus.
//
// Ports:
//   clk               in         system clock
//   reset             in         asynchronous reset, active low
//   cs                in         chip select for this block's I/O window
//   data_m_addr       in  [1:1]  word select
//   data_m_data_in    in  [15:0] write data
//   data_m_data_out   out [15:0] registered read data (0 when not reading)
//   data_m_bytesel    in  [1:0]  byte enables
//   data_m_wr_en      in         1 = write, 0 = read
//   data_m_access     in         bus access strobe
//   data_m_ack        out        access acknowledge, one cycle after access
//   irq               in  [7:0]  request lines, rising-edge sensitive
//   inta              in         single-cycle interrupt acknowledge
//   intr              out        interrupt request to the CPU
//   irq_vector        out [7:0]  vector of the last acknowledge
//   irq_vector_valid  out        one-cycle strobe qualifying irq_vector
//
// Register map (word / byte):
//   0 / 0  write: command (EOI), read: IRR
//   0 / 1  IMR, read/write
//   1 / 0  ISR, read-only
//   1 / 1  vector base, read returns {VB, 3'b000}
// ---------------------------------------------------------------------------
module interrupt_controller
  import pic_pkg::*;
#(
  parameter logic [7:0] VECTOR_BASE_RESET = 8'h08
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic [1:1]   data_m_addr,
  input  logic [15:0]  data_m_data_in,
  output logic [15:0]  data_m_data_out,
  input  logic [1:0]   data_m_bytesel,
  input  logic         data_m_wr_en,
  input  logic         data_m_access,
  output logic         data_m_ack,
  input  logic [7:0]   irq,
  input  logic         inta,
  output logic         intr,
  output logic [7:0]   irq_vector,
  output logic         irq_vector_valid
);

  // Architectural state
  irq_vec_t   irr;
  irq_vec_t   isr;
  irq_vec_t   imr;
  logic [4:0] vb;
  irq_vec_t   irq_prev;

  // Bus decode
  logic access;
  logic bus_wr;
  logic bus_rd;
  logic cmd_wr;
  logic imr_wr;
  logic vb_wr;

  // Next-state terms
  irq_vec_t    edges;
  irq_vec_t    eoi_clr;
  irq_vec_t    ack_set;
  irq_vec_t    irr_next;
  irq_vec_t    isr_next;
  logic [15:0] rd_word;
  logic [15:0] rd_next;
  logic [7:0]  vector_next;

  // Priority resolver output
  logic       prio_any;
  logic [2:0] prio_level;

  // Command bits that carry no meaning still have to land somewhere
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{data_m_data_in[7], data_m_data_in[4:3]};

  // One resolver over the current state serves both the registered intr
  // output and the acknowledge selection, so both always agree on what was
  // eligible before this cycle's updates.
  pic_priority u_priority (
    .irr   (irr),
    .imr   (imr),
    .isr   (isr),
    .any   (prio_any),
    .level (prio_level)
  );

  // Bus access qualification and register-select decode
  always_comb begin
    access = cs & data_m_access;
    bus_wr = access & data_m_wr_en;
    bus_rd = access & ~data_m_wr_en;
    cmd_wr = bus_wr & (data_m_addr[1] == WORD_CTRL)   & data_m_bytesel[BYTE_LO];
    imr_wr = bus_wr & (data_m_addr[1] == WORD_CTRL)   & data_m_bytesel[BYTE_HI];
    vb_wr  = bus_wr & (data_m_addr[1] == WORD_STATUS) & data_m_bytesel[BYTE_HI];
  end

  // Next values of IRR and ISR. Clears are applied before sets so that a
  // fresh edge beats an acknowledge clear on IRR, and an acknowledge set
  // beats an EOI clear on ISR. The non-specific EOI looks at the ISR value
  // from before this cycle's acknowledge.
  always_comb begin
    edges   = irq & ~irq_prev;
    eoi_clr = '0;
    ack_set = '0;

    if (cmd_wr) begin
      case (decode_cmd(data_m_data_in[7:0]))
        CMD_EOI_NONSPEC:  eoi_clr = lowest_set(isr);
        CMD_EOI_SPECIFIC: eoi_clr[data_m_data_in[2:0]] = 1'b1;
        default:          eoi_clr = '0;
      endcase
    end

    if (inta && prio_any) begin
      ack_set[prio_level] = 1'b1;
    end

    irr_next = (irr & ~ack_set) | edges;
    isr_next = (isr & ~eoi_clr) | ack_set;
  end

  // Vector for an acknowledge; a spurious ack reports the reserved level
  always_comb begin
    vector_next = {vb, prio_any ? prio_level : SPURIOUS_LEVEL};
  end

  // Read data path: pick the addressed word, then zero unselected byte lanes
  always_comb begin
    rd_word = (data_m_addr[1] == WORD_CTRL) ? {imr, irr} : {vb, 3'b000, isr};
    rd_next = '0;
    if (bus_rd) begin
      if (data_m_bytesel[BYTE_LO]) begin
        rd_next[7:0] = rd_word[7:0];
      end
      if (data_m_bytesel[BYTE_HI]) begin
        rd_next[15:8] = rd_word[15:8];
      end
    end
  end

  // Controller state, bus response and CPU-side outputs. intr is the
  // registered eligibility of the state held during the previous cycle, so
  // it follows any IRR/ISR/IMR change by one clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irr              <= '0;
      isr              <= '0;
      imr              <= '1;
      vb               <= VECTOR_BASE_RESET[7:3];
      irq_prev         <= '0;
      intr             <= 1'b0;
      irq_vector       <= '0;
      irq_vector_valid <= 1'b0;
      data_m_data_out  <= '0;
      data_m_ack       <= 1'b0;
    end else begin
      irq_prev         <= irq;
      irr              <= irr_next;
      isr              <= isr_next;
      intr             <= prio_any;
      irq_vector_valid <= inta;
      data_m_ack       <= access;
      data_m_data_out  <= rd_next;
      if (imr_wr) begin
        imr <= data_m_data_in[15:8];
      end
      if (vb_wr) begin
        vb <= data_m_data_in[15:11];
      end
      if (inta) begin
        irq_vector <= vector_next;
      end
    end
  end

endmodule
